// File: rtl/four_request_round_robin_arbiter.sv
// four_request_round_robin_arbiter: 4-way round-robin arbiter with hold-until-release grants.
// Define ARB_TIMEOUT_EN to force release after HOLD_MAX consecutive grant cycles.
module four_request_round_robin_arbiter #(
    parameter int HOLD_MAX = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] grant_id,
    output logic       busy,
    output logic       any_req,
    output logic       timeout
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t     state, state_nxt;
    logic [1:0] owner, owner_nxt, last_id, last_id_nxt, pick;
    logic       force_rel;

    if (HOLD_MAX < 2) begin : g_hold_check
        $error("HOLD_MAX must be at least 2");
    end

    assign any_req = |req;

    // Lowest offset from last_id+1 wins; offset 4 wraps back to last_id itself.
    always_comb begin
        pick = last_id;
        for (int k = 4; k >= 1; k--)
            if (req[last_id + 2'(k)]) pick = last_id + 2'(k);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            owner   <= 2'd0;
            last_id <= 2'd3;
        end else begin
            state   <= state_nxt;
            owner   <= owner_nxt;
            last_id <= last_id_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        owner_nxt   = owner;
        last_id_nxt = last_id;
        if (state == IDLE) begin
            if (any_req) begin
                state_nxt = GRANT;
                owner_nxt = pick;
            end
        end else if (!req[owner] || force_rel) begin
            state_nxt   = IDLE;
            last_id_nxt = owner;
        end
    end

    always_comb begin
        busy     = state == GRANT;
        grant    = busy ? 4'b0001 << owner : 4'b0000;
        grant_id = busy ? owner : 2'd0;
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(HOLD_MAX + 1);
    logic [CW-1:0] hold_cnt;
    logic          timeout_q;

    assign force_rel = state == GRANT && req[owner] && hold_cnt == CW'(HOLD_MAX - 1);
    assign timeout   = timeout_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            hold_cnt  <= state == GRANT ? hold_cnt + 1'b1 : '0;
            timeout_q <= force_rel;
        end
    end
`else
    assign force_rel = 1'b0;
    assign timeout   = 1'b0;
`endif
endmodule

// File: tb/tb_four_request_round_robin_arbiter.sv
// tb_four_request_round_robin_arbiter: directed bench with an owner/last-served reference model.
module tb_four_request_round_robin_arbiter;
    localparam int HOLD_MAX = 16;
    logic       clk = 0;
    logic       reset = 1;
    logic [3:0] req = 0;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       busy, any_req, timeout;
    int         checks = 0, errors = 0;

    four_request_round_robin_arbiter #(.HOLD_MAX(HOLD_MAX)) dut (
        .clk(clk), .reset(reset), .req(req), .grant(grant), .grant_id(grant_id),
        .busy(busy), .any_req(any_req), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: owner = -1 when idle; m_held counts visible grant cycles.
    int m_owner = -1, m_last = 3, m_held = 0;
    bit m_to = 0;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_owner = -1; m_last = 3; m_held = 0; m_to = 0;
        end else begin
            m_to = 0;
            if (m_owner < 0) begin
                for (int k = 1; k <= 4; k++)
                    if (m_owner < 0 && req[(m_last + k) % 4]) m_owner = (m_last + k) % 4;
                m_held = 1;
            end else if (!req[m_owner]) begin
                m_last = m_owner; m_owner = -1;
            end else begin
`ifdef ARB_TIMEOUT_EN
                if (m_held == HOLD_MAX) begin
                    m_last = m_owner; m_owner = -1; m_to = 1;
                end else m_held++;
`else
                m_held++;
`endif
            end
        end
    end

    always @(negedge clk) begin
        chk("model_grant", int'(grant), m_owner < 0 ? 0 : (1 << m_owner));
        chk("model_grant_id", int'(grant_id), m_owner < 0 ? 0 : m_owner);
        chk("model_busy", int'(busy), int'(m_owner >= 0));
        chk("model_timeout", int'(timeout), int'(m_to));
        chk("model_any_req", int'(any_req), int'(req != 4'b0000));
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_grant(input string name);
        int n = 0;
        do begin tick(); n++; end while (grant == 4'b0000 && n < 20);
        if (grant == 4'b0000) chk({name, "_wait_expired"}, 0, 1);
    endtask

    task automatic do_reset();
        #1 reset = 1;
        #1 reset = 0;
        tick();
    endtask

    logic [3:0] seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    int n;

    initial begin
        repeat (2) @(posedge clk);
        #1 chk("rst_grant", int'(grant), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_timeout", int'(timeout), 0);
        #1 reset = 0;
        // async reset mid-grant, then priority restarts at 0
        req = 4'b0010;
        tick(); chk("t1_grant", int'(grant), 2);
        #1 reset = 1;
        #1 chk("t1_async_grant", int'(grant), 0);
        chk("t1_async_busy", int'(busy), 0);
        chk("t1_async_id", int'(grant_id), 0);
        #1 reset = 0;
        req = 4'b1111;
        tick(); chk("t1_after_rst", int'(grant), 1);
        #1 req = 4'b0000;
        tick(); tick();
        // single requester, hold, drop
        #1 req = 4'b0100;
        tick(); chk("t2_grant", int'(grant), 4);
        chk("t2_id", int'(grant_id), 2);
        chk("t2_busy", int'(busy), 1);
        repeat (5) begin tick(); chk("t2_hold", int'(grant), 4); end
        #1 req = 4'b0000;
        tick(); chk("t2_release", int'(grant), 0);
        // fairness rotation with all four requesting
        do_reset();
        #1 req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_grant("t3");
            chk("t3_seq", int'(grant), int'(seq[i]));
            tick(); tick();
            #1 req = 4'b1111 & ~grant;
            tick(); chk("t3_gap", int'(grant), 0);
            #1 req = 4'b1111;
        end
        #1 req = 4'b0000;
        tick(); tick();
        // wrap 3 -> 0 with release and new request in the same cycle
        do_reset();
        #1 req = 4'b1000;
        wait_grant("t4");
        chk("t4_owner3", int'(grant), 8);
        #1 req = 4'b0001;
        tick(); chk("t4_gap", int'(grant), 0);
        tick(); chk("t4_wrap", int'(grant), 1);
        #1 req = 4'b0000;
        tick(); tick();
        // lone requester held continuously
        do_reset();
        #1 req = 4'b0010;
        wait_grant("t5");
        n = 1;
`ifdef ARB_TIMEOUT_EN
        while (n < 200) begin
            tick();
            if (grant == 4'b0010) n++; else break;
        end
        chk("t5_hold_len", n, 16);
        chk("t5_timeout", int'(timeout), 1);
        chk("t5_idle", int'(grant), 0);
        tick(); chk("t5_regrant", int'(grant), 2);
        chk("t5_timeout_clr", int'(timeout), 0);
`else
        repeat (120) begin
            tick();
            if (grant == 4'b0010) n++;
        end
        chk("t6_hold_len", n, 121);
        chk("t6_timeout", int'(timeout), 0);
`endif
        #1 req = 4'b0000;
        tick(); tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
